if_burst_injector: RTL and testbench

//   Parametrised intermittent-fault injector that sits between a benchmark gate netlist and its consumer.
//   It registers a WIDTH-bit net bus and corrupts one selected bit in bursts: stuck-at-0, stuck-at-1 or bit-flip.

---
 rtl/if_burst_injector.sv | 209 ++++++++++++++++++++
 tb/tb_if_burst_injector.sv | 305 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/if_burst_injector.sv
// if_burst_injector
//   Intermittent-fault injector placed between a gate netlist and its consumer.
//   The WIDTH-bit net bus is registered. While a burst runs, one selected bit is
//   forced to 0, forced to 1 or inverted. Burst length, gap length and burst
//   count are programmable, and the gap can be lengthened by an LFSR value.
//   fault_active labels the cycles on which sig_out carries the corruption.
//
// Ports
//   clk, rst_n      rising-edge clock, synchronous active-low reset
//   en              run enable; low aborts the run and returns to IDLE
//   sig_in/sig_out  fault-free input bus / registered, possibly corrupted bus
//   cfg_valid/ready configuration handshake; ready = IDLE & en
//   cfg_target      bit to corrupt (>= WIDTH: timing runs, nothing corrupted)
//   cfg_type        00 SA0, 01 SA1, 10 flip, 11 none
//   cfg_gap_min     base gap cycles (0 behaves as 1)
//   cfg_rand_en     add lfsr[RAND_W-1:0] to the gap
//   cfg_burst_len   burst cycles (0 behaves as 1)
//   cfg_num_bursts  bursts per run (0 = unbounded)
//   cfg_seed        LFSR seed (0 is replaced by 16'hACE1)
//   fault_active    high on the cycles sig_out is inside a corruption window
//   burst_count     completed bursts since the last accept, saturating
module if_burst_injector #(
  parameter int unsigned WIDTH  = 8,
  parameter int unsigned CNT_W  = 8,
  parameter int unsigned RAND_W = 4
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     en,
  input  logic [WIDTH-1:0]         sig_in,
  output logic [WIDTH-1:0]         sig_out,
  input  logic                     cfg_valid,
  output logic                     cfg_ready,
  input  logic [$clog2(WIDTH)-1:0] cfg_target,
  input  logic [1:0]               cfg_type,
  input  logic [CNT_W-1:0]         cfg_gap_min,
  input  logic                     cfg_rand_en,
  input  logic [CNT_W-1:0]         cfg_burst_len,
  input  logic [CNT_W-1:0]         cfg_num_bursts,
  input  logic [15:0]              cfg_seed,
  output logic                     fault_active,
  output logic [15:0]              burst_count
);

  localparam int unsigned TW = $clog2(WIDTH);
  localparam int unsigned GW = CNT_W + 1;
  localparam logic [15:0] LFSR_RESET = 16'hACE1;
  localparam logic [15:0] LFSR_MASK  = 16'hB400;

  typedef enum logic [1:0] {
    S_IDLE,
    S_GAP,
    S_BURST
  } state_t;

  state_t            state_q, state_d;
  logic [GW-1:0]     cnt_q, cnt_d;
  logic              load_q, load_d;
  logic [15:0]       lfsr_q, lfsr_d;
  logic [15:0]       bcnt_q, bcnt_d;
  logic [WIDTH-1:0]  out_q, out_d;
  logic              fa_q, fa_d;

  logic [TW-1:0]     tgt_q, tgt_d;
  logic [1:0]        type_q, type_d;
  logic [CNT_W-1:0]  gmin_q, gmin_d;
  logic              rnd_q, rnd_d;
  logic [CNT_W-1:0]  blen_q, blen_d;
  logic [CNT_W-1:0]  num_q, num_d;

  logic [15:0]       lfsr_step;
  logic [GW-1:0]     gap_now;
  logic [GW-1:0]     blen_eff;
  logic              tgt_ok;
  logic [WIDTH-1:0]  mask;
  logic              last_burst;

  function automatic logic [GW-1:0] gap_len(input logic [CNT_W-1:0] gmin,
                                            input logic             rnd,
                                            input logic [15:0]      lv);
    logic [GW-1:0] base;
    base = (gmin == '0) ? GW'(1) : GW'(gmin);
    return base + (rnd ? GW'(lv[RAND_W-1:0]) : '0);
  endfunction

  assign lfsr_step = {1'b0, lfsr_q[15:1]} ^ (lfsr_q[0] ? LFSR_MASK : '0);
  assign gap_now   = gap_len(gmin_q, rnd_q, lfsr_q);
  assign blen_eff  = (blen_q == '0) ? GW'(1) : GW'(blen_q);
  assign tgt_ok    = ({1'b0, tgt_q} < (TW + 1)'(WIDTH));
  assign mask      = tgt_ok ? (WIDTH'(1) << tgt_q) : '0;
  assign last_burst = (num_q != '0) &&
                      (({1'b0, bcnt_q} + 17'd1) == 17'(num_q));

  assign cfg_ready    = (state_q == S_IDLE) && en;
  assign sig_out      = out_q;
  assign fault_active = fa_q;
  assign burst_count  = bcnt_q;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    load_d  = load_q;
    lfsr_d  = lfsr_q;
    bcnt_d  = bcnt_q;
    tgt_d   = tgt_q;
    type_d  = type_q;
    gmin_d  = gmin_q;
    rnd_d   = rnd_q;
    blen_d  = blen_q;
    num_d   = num_q;

    if (!en) begin
      state_d = S_IDLE;
    end else begin
      unique case (state_q)
        S_IDLE: begin
          if (cfg_valid) begin
            tgt_d   = cfg_target;
            type_d  = cfg_type;
            gmin_d  = cfg_gap_min;
            rnd_d   = cfg_rand_en;
            blen_d  = cfg_burst_len;
            num_d   = cfg_num_bursts;
            bcnt_d  = '0;
            lfsr_d  = (cfg_seed == '0) ? LFSR_RESET : cfg_seed;
            load_d  = 1'b1;
            state_d = S_GAP;
          end
        end
        S_GAP: begin
          lfsr_d = lfsr_step;
          // The first GAP cycle after an accept only loads the counter, because
          // the latched config and seeded LFSR become visible on that cycle.
          if (load_q) begin
            cnt_d  = gap_now;
            load_d = 1'b0;
          end else if (cnt_q <= GW'(1)) begin
            cnt_d   = blen_eff;
            state_d = S_BURST;
          end else begin
            cnt_d = cnt_q - GW'(1);
          end
        end
        S_BURST: begin
          lfsr_d = lfsr_step;
          if (cnt_q <= GW'(1)) begin
            bcnt_d = (bcnt_q == 16'hFFFF) ? bcnt_q : bcnt_q + 16'd1;
            if (last_burst) begin
              state_d = S_IDLE;
            end else begin
              cnt_d   = gap_now;
              state_d = S_GAP;
            end
          end else begin
            cnt_d = cnt_q - GW'(1);
          end
        end
        default: state_d = S_IDLE;
      endcase
    end
  end

  always_comb begin
    out_d = sig_in;
    fa_d  = 1'b0;
    if (en && (state_q == S_BURST)) begin
      unique case (type_q)
        2'b00:   out_d = sig_in & ~mask;
        2'b01:   out_d = sig_in | mask;
        2'b10:   out_d = sig_in ^ mask;
        default: out_d = sig_in;
      endcase
      fa_d = (type_q != 2'b11) && tgt_ok;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      load_q  <= 1'b0;
      lfsr_q  <= LFSR_RESET;
      bcnt_q  <= '0;
      out_q   <= '0;
      fa_q    <= 1'b0;
      tgt_q   <= '0;
      type_q  <= '0;
      gmin_q  <= '0;
      rnd_q   <= 1'b0;
      blen_q  <= '0;
      num_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      load_q  <= load_d;
      lfsr_q  <= lfsr_d;
      bcnt_q  <= bcnt_d;
      out_q   <= out_d;
      fa_q    <= fa_d;
      tgt_q   <= tgt_d;
      type_q  <= type_d;
      gmin_q  <= gmin_d;
      rnd_q   <= rnd_d;
      blen_q  <= blen_d;
      num_q   <= num_d;
    end
  end

endmodule

// File: tb/tb_if_burst_injector.sv
// Bench for if_burst_injector (WIDTH=8, CNT_W=8, RAND_W=4). A behavioural model
// derives the burst schedule of each run from the latched configuration and the
// LFSR sequence, then predicts every registered output cycle by cycle.
module tb_if_burst_injector;

  localparam int MAXK = 2048;
  localparam int MAXB = 1024;

  logic        clk = 1'b0;
  logic        rst_n, en, cfg_valid, cfg_ready, cfg_rand_en, fault_active;
  logic [7:0]  sig_in, sig_out, cfg_gap_min, cfg_burst_len, cfg_num_bursts;
  logic [2:0]  cfg_target;
  logic [1:0]  cfg_type;
  logic [15:0] cfg_seed, burst_count;

  logic        rand_sig = 1'b0;
  logic [7:0]  sig_fixed = 8'h00;
  int          n_cmp = 0, n_bad = 0;
  int          dut_acc = 0;

  if_burst_injector #(.WIDTH(8), .CNT_W(8), .RAND_W(4)) dut (
    .clk(clk), .rst_n(rst_n), .en(en), .sig_in(sig_in), .sig_out(sig_out),
    .cfg_valid(cfg_valid), .cfg_ready(cfg_ready), .cfg_target(cfg_target),
    .cfg_type(cfg_type), .cfg_gap_min(cfg_gap_min), .cfg_rand_en(cfg_rand_en),
    .cfg_burst_len(cfg_burst_len), .cfg_num_bursts(cfg_num_bursts),
    .cfg_seed(cfg_seed), .fault_active(fault_active), .burst_count(burst_count)
  );

  always #5 clk = ~clk;

  always @(negedge clk) sig_in = rand_sig ? 8'($urandom) : sig_fixed;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  logic        m_idle = 1'b1;
  logic [7:0]  m_out = '0;
  logic        m_fa = 1'b0;
  logic [15:0] m_bc = '0;
  int          m_k = 0, m_acc = 0, m_nb = 0, m_len = 1;
  int          m_bst[MAXB];
  logic [15:0] m_lf[MAXK+1];
  logic [2:0]  m_tgt;
  logic [1:0]  m_type;
  logic [7:0]  m_num;

  function automatic int gap_of(input logic [7:0] gmin, input logic rnd, input logic [15:0] lv);
    int g;
    g = (gmin == 0) ? 1 : int'(gmin);
    if (rnd) g += int'(lv[3:0]);
    return g;
  endfunction

  // Cycle k=1 follows the accept edge; LFSR holds the seed on k=1 and shifts
  // once per run cycle. The first gap is timed after one setup cycle; later
  // gaps start right after each burst and use the LFSR of its last cycle.
  task automatic plan_run(input logic [7:0] gmin, input logic rnd, input logic [7:0] blen,
                          input logic [7:0] num, input logic [15:0] seed);
    logic [15:0] v;
    int start, lim;
    v = (seed == 0) ? 16'hACE1 : seed;
    for (int k = 1; k <= MAXK; k++) begin
      m_lf[k] = v;
      v = (v >> 1) ^ (v[0] ? 16'hB400 : 16'h0000);
    end
    m_len = (blen == 0) ? 1 : int'(blen);
    lim   = (num == 0) ? MAXB : int'(num);
    m_nb  = 0;
    start = 2 + gap_of(gmin, rnd, m_lf[1]);
    while (m_nb < lim && start + m_len < MAXK) begin
      m_bst[m_nb] = start;
      m_nb++;
      start = start + m_len + gap_of(gmin, rnd, m_lf[start + m_len - 1]);
    end
  endtask

  function automatic int burst_at(input int k);
    for (int i = 0; i < m_nb; i++) begin
      if (m_bst[i] > k) return -1;
      if (k < m_bst[i] + m_len) return i;
    end
    return -1;
  endfunction

  function automatic logic [7:0] corrupt(input logic [7:0] d);
    logic [7:0] msk;
    msk = 8'h01 << m_tgt;
    case (m_type)
      2'b00:   return d & ~msk;
      2'b01:   return d | msk;
      2'b10:   return d ^ msk;
      default: return d;
    endcase
  endfunction

  always @(posedge clk) begin
    int idx;
    if (!rst_n) begin
      m_idle = 1'b1; m_out = '0; m_fa = 1'b0; m_bc = '0;
    end else if (!en) begin
      m_idle = 1'b1; m_out = sig_in; m_fa = 1'b0;
    end else if (m_idle) begin
      m_out = sig_in; m_fa = 1'b0;
      if (cfg_valid) begin
        m_tgt = cfg_target; m_type = cfg_type; m_num = cfg_num_bursts;
        plan_run(cfg_gap_min, cfg_rand_en, cfg_burst_len, cfg_num_bursts, cfg_seed);
        m_bc = '0; m_idle = 1'b0; m_k = 1; m_acc++;
      end
    end else begin
      idx = burst_at(m_k);
      if (idx >= 0) begin
        m_out = corrupt(sig_in);
        m_fa  = (m_type != 2'b11);
        if (m_k == m_bst[idx] + m_len - 1) begin
          if (m_bc != 16'hFFFF) m_bc = m_bc + 16'd1;
          if (m_num != 0 && idx + 1 == int'(m_num)) m_idle = 1'b1;
        end
      end else begin
        m_out = sig_in; m_fa = 1'b0;
      end
      m_k++;
    end
  end

  always @(posedge clk) if (rst_n && en && cfg_valid && cfg_ready) dut_acc++;

  always @(posedge clk) begin
    #1;
    chk("sig_out", 32'(sig_out), 32'(m_out));
    chk("fault_active", 32'(fault_active), 32'(m_fa));
    chk("burst_count", 32'(burst_count), 32'(m_bc));
    chk("cfg_ready", 32'(cfg_ready), 32'(m_idle & en));
  end

  // ---------------- stimulus ----------------
  task automatic set_cfg(input logic [2:0] t, input logic [1:0] ty, input logic [7:0] g,
                         input logic r, input logic [7:0] b, input logic [7:0] n,
                         input logic [15:0] s);
    cfg_target = t; cfg_type = ty; cfg_gap_min = g; cfg_rand_en = r;
    cfg_burst_len = b; cfg_num_bursts = n; cfg_seed = s;
  endtask

  task automatic accept();
    @(negedge clk); cfg_valid = 1'b1;
    @(posedge clk); #1; cfg_valid = 1'b0;
  endtask

  task automatic wait_idle(input int budget);
    int n = 0;
    while (!cfg_ready && n < budget) begin @(posedge clk); #1; n++; end
    if (!cfg_ready) chk("idle_timeout", 32'(cfg_ready), 32'd1);
  endtask

  task automatic do_reset();
    @(negedge clk); rst_n = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk); rst_n = 1'b1; en = 1'b1;
    @(posedge clk); #1;
  endtask

  logic [7:0] tr_o1[101], tr_o2[101];
  logic       tr_f1[101], tr_f2[101];

  initial begin
    int diffs, acc0, dacc0;
    logic e6;
    rst_n = 1'b0; en = 1'b0; cfg_valid = 1'b0;
    set_cfg(3'd0, 2'b00, 8'd0, 1'b0, 8'd0, 8'd0, 16'd0);
    do_reset();
    chk("reset_sig_out", 32'(sig_out), 32'h0);
    chk("reset_bc", 32'(burst_count), 32'h0);
    chk("ready_after_reset", 32'(cfg_ready), 32'h1);

    // T1 deterministic SA1
    set_cfg(3'd3, 2'b01, 8'd4, 1'b0, 8'd2, 8'd3, 16'd0);
    accept();
    for (int i = 1; i <= 20; i++) begin
      @(posedge clk); #1;
      e6 = (i == 6 || i == 7 || i == 12 || i == 13 || i == 18 || i == 19);
      chk("t1_fa", 32'(fault_active), 32'(e6));
      chk("t1_out", 32'(sig_out), e6 ? 32'h08 : 32'h00);
      if (i == 19) begin
        chk("t1_bc", 32'(burst_count), 32'd3);
        chk("t1_ready", 32'(cfg_ready), 32'd1);
      end
    end

    // T2 flip / SA0 / SA1 on all-ones
    sig_fixed = 8'hFF;
    for (int t = 0; t < 3; t++) begin
      set_cfg(3'd3, (t == 0) ? 2'b10 : (t == 1) ? 2'b00 : 2'b01, 8'd4, 1'b0, 8'd2, 8'd3, 16'd0);
      accept();
      repeat (6) @(posedge clk);
      #1;
      chk("t2_out", 32'(sig_out), (t == 2) ? 32'hFF : 32'hF7);
      chk("t2_fa", 32'(fault_active), 32'd1);
      wait_idle(40);
    end

    // T3 zero-length fields
    sig_fixed = 8'h00;
    set_cfg(3'd3, 2'b01, 8'd0, 1'b0, 8'd0, 8'd2, 16'd0);
    accept();
    for (int i = 1; i <= 7; i++) begin
      @(posedge clk); #1;
      chk("t3_fa", 32'(fault_active), 32'(i == 3 || i == 5));
      if (i == 5) chk("t3_ready", 32'(cfg_ready), 32'd1);
    end

    // T4 randomised gap, reproducible with the same seed
    set_cfg(3'd5, 2'b10, 8'd4, 1'b1, 8'd2, 8'd4, 16'h0001);
    accept();
    for (int i = 1; i <= 100; i++) begin @(posedge clk); #1; tr_o1[i] = sig_out; tr_f1[i] = fault_active; end
    wait_idle(40);
    accept();
    for (int i = 1; i <= 100; i++) begin @(posedge clk); #1; tr_o2[i] = sig_out; tr_f2[i] = fault_active; end
    diffs = 0;
    for (int i = 1; i <= 100; i++) if (tr_o1[i] !== tr_o2[i] || tr_f1[i] !== tr_f2[i]) diffs++;
    chk("t4_repro_diffs", 32'(diffs), 32'd0);
    chk("t4_fa6", 32'(tr_f1[6]), 32'd0);
    chk("t4_fa7", 32'(tr_f1[7]), 32'd1);
    chk("t4_fa12", 32'(tr_f1[12]), 32'd0);
    chk("t4_fa13", 32'(tr_f1[13]), 32'd1);
    wait_idle(40);

    // T5 abort by en, then by reset, during the 2nd burst
    sig_fixed = 8'hFF;
    for (int t = 0; t < 2; t++) begin
      set_cfg(3'd2, 2'b10, 8'd2, 1'b0, 8'd3, 8'd5, 16'd0);
      accept();
      repeat (9) @(posedge clk);
      @(negedge clk);
      if (t == 0) en = 1'b0; else rst_n = 1'b0;
      @(posedge clk); #1;
      chk("t5_out", 32'(sig_out), (t == 0) ? 32'hFF : 32'h00);
      chk("t5_fa", 32'(fault_active), 32'd0);
      chk("t5_bc", 32'(burst_count), (t == 0) ? 32'd1 : 32'd0);
      @(negedge clk); en = 1'b1; rst_n = 1'b1;
      @(posedge clk); #1;
      chk("t5_ready", 32'(cfg_ready), 32'd1);
    end

    // T6 held cfg_valid: one accept per IDLE visit
    sig_fixed = 8'h00;
    acc0 = m_acc; dacc0 = dut_acc;
    set_cfg(3'd1, 2'b00, 8'd1, 1'b0, 8'd1, 8'd1, 16'd0);
    @(negedge clk); cfg_valid = 1'b1;
    repeat (40) @(posedge clk);
    @(negedge clk); cfg_valid = 1'b0;
    wait_idle(20);
    chk("t6_accepts", 32'(dut_acc - dacc0), 32'(m_acc - acc0));
    chk("t6_accepts_lit", 32'(m_acc - acc0), 32'd10);

    // T6 unbounded run and burst_count saturation
    set_cfg(3'd7, 2'b01, 8'd1, 1'b0, 8'd1, 8'd0, 16'd0);
    accept();
    repeat (20) @(posedge clk);
    @(negedge clk);
    force dut.bcnt_q = 16'hFFFD;
    m_bc = 16'hFFFD;
    #1 release dut.bcnt_q;
    repeat (20) @(posedge clk);
    #1;
    chk("t6_sat", 32'(burst_count), 32'hFFFF);
    @(negedge clk); en = 1'b0;
    @(posedge clk); #1;
    chk("t6_hold", 32'(burst_count), 32'hFFFF);
    @(negedge clk); en = 1'b1;

    // randomised configurations with random data, en drops and resets
    rand_sig = 1'b1;
    for (int it = 0; it < 40; it++) begin
      set_cfg(3'($urandom), 2'($urandom), 8'($urandom_range(0, 6)), 1'($urandom),
              8'($urandom_range(0, 4)), 8'($urandom_range(0, 4)),
              ($urandom_range(0, 3) == 0) ? 16'd0 : 16'($urandom));
      accept();
      for (int c = 0; c < int'($urandom_range(20, 150)); c++) begin
        @(negedge clk);
        if ($urandom_range(0, 60) == 0) en = 1'b0;
        else if ($urandom_range(0, 150) == 0) rst_n = 1'b0;
        else begin en = 1'b1; rst_n = 1'b1; end
      end
      @(negedge clk); en = 1'b0; rst_n = 1'b1;
      @(negedge clk); en = 1'b1;
    end
    rand_sig = 1'b0;
    repeat (3) @(posedge clk);
    #2;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish, compared %0d mismatched %0d", n_cmp, n_bad);
    $fatal(1);
  end

endmodule
